// File: rtl/i2c_master_sequencer.sv
// Byte-level I2C master: executes START / WRITE / READ / STOP commands as
// quarter-bit sequences on open-drain SCL/SDA enables, with clock stretching.
module i2c_master_sequencer #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd,
  input  logic [7:0]       wdata,
  input  logic             tx_nack,
  input  logic [DIV_W-1:0] div,
  output logic [7:0]       rdata,
  output logic             rx_nack,
  output logic             done,
  output logic             busy,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             scl_oe,
  output logic             sda_oe
);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BIT   = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [3:0]       bit_q, bit_d;
  logic [1:0]       op_q, op_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             tx_nack_q, tx_nack_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       shift_q, shift_d;
  logic             ack_q, ack_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rx_nack_q, rx_nack_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             scl_oe_q, scl_oe_d;
  logic             sda_oe_q, sda_oe_d;
  logic             tick, stall;

  // Next-state, sampling and registered line-drive computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    op_d      = op_q;
    wdata_d   = wdata_q;
    tx_nack_d = tx_nack_q;
    div_d     = div_q;
    shift_d   = shift_q;
    ack_d     = ack_q;
    rdata_d   = rdata_q;
    rx_nack_d = rx_nack_q;
    done_d    = 1'b0;
    scl_oe_d  = scl_oe_q;
    sda_oe_d  = sda_oe_q;

    tick  = (cnt_q == div_q);
    // A slave holding SCL low at the end of Q1 freezes the sequence
    stall = (qtr_q == 2'd1) && tick && !scl_i;

    if (state_q == S_IDLE) begin
      if (cmd_valid) begin
        op_d      = cmd;
        wdata_d   = wdata;
        tx_nack_d = tx_nack;
        div_d     = div;
        cnt_d     = '0;
        qtr_d     = 2'd0;
        bit_d     = 4'd8;
        case (cmd)
          CMD_START: state_d = S_START;
          CMD_STOP:  state_d = S_STOP;
          default:   state_d = S_BIT;
        endcase
      end
    end else if (!tick) begin
      cnt_d = cnt_q + DIV_W'(1);
    end else if (!stall) begin
      cnt_d = '0;
      if (qtr_q == 2'd2 && state_q == S_BIT) begin
        if (op_q == CMD_READ) begin
          if (bit_q != 4'd0) shift_d = {shift_q[6:0], sda_i};
        end else if (bit_q == 4'd0) begin
          ack_d = sda_i;
        end
      end
      if (qtr_q == 2'd3) begin
        if (state_q == S_BIT && bit_q != 4'd0) begin
          bit_d = bit_q - 4'd1;
          qtr_d = 2'd0;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          // Results become visible only when the command completes
          if (state_q == S_BIT) begin
            if (op_q == CMD_READ) rdata_d = shift_q;
            else                  rx_nack_d = ack_q;
          end
        end
      end else begin
        qtr_d = qtr_q + 2'd1;
      end
    end

    case (state_d)
      S_START: begin
        scl_oe_d = (qtr_d >= 2'd2);
        sda_oe_d = (qtr_d != 2'd0);
      end
      S_STOP: begin
        scl_oe_d = (qtr_d == 2'd0);
        sda_oe_d = (qtr_d <= 2'd1);
      end
      S_BIT: begin
        scl_oe_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
        if (op_d == CMD_READ) sda_oe_d = (bit_d == 4'd0) && !tx_nack_d;
        else                  sda_oe_d = (bit_d != 4'd0) && !wdata_d[3'(bit_d - 4'd1)];
      end
      default: ;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 4'd0;
      op_q      <= 2'd0;
      wdata_q   <= 8'h00;
      tx_nack_q <= 1'b0;
      div_q     <= '0;
      shift_q   <= 8'h00;
      ack_q     <= 1'b0;
      rdata_q   <= 8'h00;
      rx_nack_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      op_q      <= op_d;
      wdata_q   <= wdata_d;
      tx_nack_q <= tx_nack_d;
      div_q     <= div_d;
      shift_q   <= shift_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      rx_nack_q <= rx_nack_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign rx_nack   = rx_nack_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Bench for i2c_master_sequencer: a quarter-table waveform model predicts every
// output on every cycle; a bus model closes the open-drain lines with a slave.
module tb_i2c_master_sequencer;

  localparam int unsigned DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd = 2'b00;
  logic [7:0]       wdata = 8'h00;
  logic             tx_nack = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [7:0]       rdata;
  logic             rx_nack;
  logic             done;
  logic             busy;
  logic             scl_i, sda_i;
  logic             scl_oe, sda_oe;
  logic             sl_scl_low = 1'b0;
  logic             sl_sda_low = 1'b0;

  i2c_master_sequencer #(.DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .wdata(wdata), .tx_nack(tx_nack), .div(div), .rdata(rdata),
    .rx_nack(rx_nack), .done(done), .busy(busy), .scl_i(scl_i), .sda_i(sda_i),
    .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  // Wired-AND bus: a line is high only if neither master nor slave pulls it
  assign scl_i = ~scl_oe & ~sl_scl_low;
  assign sda_i = ~sda_oe & ~sl_sda_low;

  typedef struct packed {
    logic       scl;
    logic       sda;
    logic       sl_scl;
    logic       sl_sda;
    logic       done;
    logic       busy;
    logic       ready;
    logic [7:0] rdata;
    logic       rx_nack;
  } ent_t;

  ent_t exp_q[$];
  logic bits_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   done_lat = -1;
  logic prev_scl = 1'b0;
  ent_t e;

  // Model state: held line enables and published results
  logic       m_scl = 1'b0, m_sda = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  logic       m_rx_nack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic void push_qtr(input logic scl, input logic sda, input int len,
                                   input logic sl_sda, input int st_from, input int st_len);
    ent_t x;
    for (int i = 0; i < len; i++) begin
      x.scl = scl; x.sda = sda; x.sl_sda = sl_sda;
      x.sl_scl = (i >= st_from) && (i < st_from + st_len);
      x.done = 1'b0; x.busy = 1'b1; x.ready = 1'b0;
      x.rdata = m_rdata; x.rx_nack = m_rx_nack;
      exp_q.push_back(x);
    end
    m_scl = scl;
    m_sda = sda;
  endfunction

  function automatic void append_idle(input int n, input logic dn);
    ent_t x;
    for (int i = 0; i < n; i++) begin
      x.scl = m_scl; x.sda = m_sda; x.sl_scl = 1'b0; x.sl_sda = 1'b0;
      x.done = dn && (i == 0); x.busy = 1'b0; x.ready = 1'b1;
      x.rdata = m_rdata; x.rx_nack = m_rx_nack;
      exp_q.push_back(x);
    end
  endfunction

  // Expected per-cycle waveform of one command, followed by its done cycle
  function automatic void append_cmd(input logic [1:0] c, input logic [7:0] w, input logic tn,
                                     input int d, input logic [7:0] sb, input logic sack,
                                     input int sbit, input int slen);
    logic oe, sl;
    int   st;
    case (c)
      2'b00: begin
        push_qtr(0, 0, d + 1, 0, 0, 0); push_qtr(0, 1, d + 1, 0, 0, 0);
        push_qtr(1, 1, d + 1, 0, 0, 0); push_qtr(1, 1, d + 1, 0, 0, 0);
      end
      2'b11: begin
        push_qtr(1, 1, d + 1, 0, 0, 0); push_qtr(0, 1, d + 1, 0, 0, 0);
        push_qtr(0, 0, d + 1, 0, 0, 0); push_qtr(0, 0, d + 1, 0, 0, 0);
      end
      default: begin
        for (int b = 8; b >= 0; b--) begin
          if (c == 2'b01) begin
            oe = (b > 0) ? ~w[b-1] : 1'b0;
            sl = (b == 0) && sack;
          end else begin
            oe = (b > 0) ? 1'b0 : ~tn;
            sl = (b > 0) && !sb[b-1];
          end
          st = (b == sbit) ? slen : 0;
          push_qtr(1, oe, d + 1, sl, 0, 0);
          push_qtr(0, oe, d + 1 + st, sl, d, st);
          push_qtr(0, oe, d + 1, sl, 0, 0);
          push_qtr(1, oe, d + 1, sl, 0, 0);
        end
        if (c == 2'b10) m_rdata = sb;
        else            m_rx_nack = ~sack;
      end
    endcase
    append_idle(1, 1'b1);
  endfunction

  // Single compare process: every queued cycle is checked against the model
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("scl_oe", {31'd0, scl_oe}, {31'd0, e.scl});
      chk("sda_oe", {31'd0, sda_oe}, {31'd0, e.sda});
      chk("done", {31'd0, done}, {31'd0, e.done});
      chk("busy", {31'd0, busy}, {31'd0, e.busy});
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, e.ready});
      chk("rdata", {24'd0, rdata}, {24'd0, e.rdata});
      chk("rx_nack", {31'd0, rx_nack}, {31'd0, e.rx_nack});
      sl_scl_low = e.sl_scl;
      sl_sda_low = e.sl_sda;
    end else begin
      sl_scl_low = 1'b0;
      sl_sda_low = 1'b0;
    end
    if (done === 1'b1) done_lat = cyc - acc_cyc - 1;
    if (prev_scl === 1'b1 && scl_oe === 1'b0) bits_q.push_back(~sda_oe);
    prev_scl = scl_oe;
  end

  task automatic wait_drain();
    for (int i = 0; i < 5000 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout got=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [1:0] c, input logic [7:0] w, input logic tn, input int d,
                     input logic [7:0] sb, input logic sack, input int sbit, input int slen);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; wdata = w; tx_nack = tn; div = DIV_W'(d);
    @(posedge clk);
    acc_cyc = cyc;
    bits_q.delete();
    append_cmd(c, w, tn, d, sb, sack, sbit, slen);
    append_idle(1, 1'b0);
    @(negedge clk);
    // Junk on the command bus must be ignored while busy
    cmd_valid = 1'b0; cmd = 2'($urandom); wdata = 8'($urandom);
    tx_nack = 1'($urandom); div = DIV_W'($urandom);
    wait_drain();
  endtask

  logic [7:0] byte_v;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    append_idle(2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain();
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // START, div=3
    run(2'b00, 8'h00, 1'b0, 3, 8'h00, 1'b0, -1, 0);
    chk("start_lat", done_lat, 32'd16);

    // WRITE 0xA5 with ACK, div=0
    run(2'b01, 8'hA5, 1'b0, 0, 8'h00, 1'b1, -1, 0);
    chk("write_lat", done_lat, 32'd36);
    chk("write_pulses", bits_q.size(), 32'd9);
    byte_v = 8'h00;
    for (int i = 0; i < 8 && i < bits_q.size(); i++) byte_v = {byte_v[6:0], bits_q[i]};
    chk("write_bits", {24'd0, byte_v}, 32'hA5);
    chk("write_ack", {31'd0, rx_nack}, 32'd0);

    // READ 0x3C with NACK, div=1
    run(2'b10, 8'h00, 1'b1, 1, 8'h3C, 1'b0, -1, 0);
    chk("read_lat", done_lat, 32'd72);
    chk("read_data", {24'd0, rdata}, 32'h3C);
    chk("read_rx_nack", {31'd0, rx_nack}, 32'd0);

    // WRITE with 10-cycle stretch at bit 5, div=0
    run(2'b01, 8'h5A, 1'b0, 0, 8'h00, 1'b1, 5, 10);
    chk("stretch_lat", done_lat, 32'd46);

    // READ with cmd_valid held, STOP queued behind it
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 2'b10; tx_nack = 1'b0; div = DIV_W'(0);
    @(posedge clk);
    acc_cyc = cyc;
    append_cmd(2'b10, 8'h00, 1'b0, 0, 8'h96, 1'b0, -1, 0);
    append_cmd(2'b11, 8'h00, 1'b0, 2, 8'h00, 1'b0, -1, 0);
    append_idle(1, 1'b0);
    @(negedge clk);
    cmd = 2'b11; div = DIV_W'(2);
    repeat (37) @(negedge clk);
    cmd_valid = 1'b0;
    wait_drain();
    chk("chain_lat", done_lat, 32'd49);
    chk("chain_rdata", {24'd0, rdata}, 32'h96);

    // Reset during WRITE bit 4
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 2'b01; wdata = 8'hC3; div = DIV_W'(0);
    @(posedge clk);
    acc_cyc = cyc;
    append_cmd(2'b01, 8'hC3, 1'b0, 0, 8'h00, 1'b1, -1, 0);
    while (exp_q.size() > 18) void'(exp_q.pop_back());
    m_scl = 1'b0; m_sda = 1'b0; m_rdata = 8'h00; m_rx_nack = 1'b0;
    append_idle(3, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain();
    chk("rst_abort_ready", {31'd0, cmd_ready}, 32'd1);

    // Randomized command mix
    for (int k = 0; k < 24; k++) begin
      logic [1:0] rc;
      int         sbit, slen;
      rc   = 2'($urandom_range(0, 3));
      sbit = $urandom_range(0, 8);
      slen = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
      run(rc, 8'($urandom), 1'($urandom), $urandom_range(0, 3), 8'($urandom),
          1'($urandom), sbit, slen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
